// File: rtl/uart_tx_arbiter_pkg.sv
// uart_arb_pkg: shared types and defaults for the UART transmit arbiter.
//   arb_state_t           - arbiter FSM state encoding
//   DEFAULT_NUM_REQ       - default number of requesters
//   DEFAULT_DATA_W        - default byte width
//   DEFAULT_START_TIMEOUT - default cycles allowed for busy to rise after start
package uart_arb_pkg;

    localparam int DEFAULT_NUM_REQ       = 4;
    localparam int DEFAULT_DATA_W        = 8;
    localparam int DEFAULT_START_TIMEOUT = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RELEASE   = 3'd4
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: bundles the requester side and the transmitter side of
// the arbiter.
//   i_req        - level request per requester
//   i_data       - byte for requester k in slice k
//   i_uart_busy  - transmitter frame in progress
//   o_start_uart - one-cycle start pulse to the transmitter
//   o_uart_data  - latched byte for the transmitter
//   o_grant      - one-hot current owner
//   o_ack        - one-hot one-cycle completion pulse
//   o_timeout    - one-cycle pulse when the transmitter never went busy
//
// Handshakes: a requester raises i_req[k] with i_data slice k valid and holds
// it until it sees o_ack[k]; it must drop the request on the edge after
// o_ack[k]. Toward the transmitter, o_start_uart is a single-cycle pulse with
// o_uart_data already valid, and i_uart_busy high marks the frame; the frame
// is complete when busy returns low.
// Modports: slave is the arbiter, master is the producer/transmitter side.
interface uart_tx_arbiter_if
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int DATA_W  = DEFAULT_DATA_W
);
    logic [NUM_REQ-1:0]        i_req;
    logic [NUM_REQ*DATA_W-1:0] i_data;
    logic                      i_uart_busy;
    logic                      o_start_uart;
    logic [DATA_W-1:0]         o_uart_data;
    logic [NUM_REQ-1:0]        o_grant;
    logic [NUM_REQ-1:0]        o_ack;
    logic                      o_timeout;

    modport slave (
        input  i_req,
        input  i_data,
        input  i_uart_busy,
        output o_start_uart,
        output o_uart_data,
        output o_grant,
        output o_ack,
        output o_timeout
    );

    modport master (
        output i_req,
        output i_data,
        output i_uart_busy,
        input  o_start_uart,
        input  o_uart_data,
        input  o_grant,
        input  o_ack,
        input  o_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search.
//   i_req    - request vector
//   i_ptr    - index where the search starts (must be < NUM_REQ)
//   o_winner - one-hot winner, zero when nothing is requested
//   o_valid  - at least one request present
// The request vector is doubled so that a search starting at i_ptr can run
// linearly past the top bit and wrap onto the low bits.
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_winner,
    output logic               o_valid
);
    // Only 2*NUM_REQ-1 bits are ever reached because i_ptr < NUM_REQ.
    logic [2*NUM_REQ-2:0] req_dbl;
    logic [2*NUM_REQ-2:0] win_dbl;

    always_comb begin
        req_dbl = {i_req[NUM_REQ-2:0], i_req};
        win_dbl = '0;
        o_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!o_valid && req_dbl[i + int'(i_ptr)]) begin
                win_dbl[i + int'(i_ptr)] = 1'b1;
                o_valid = 1'b1;
            end
        end
        // Fold the upper copy back onto the real requester positions.
        o_winner = win_dbl[NUM_REQ-1:0] | {1'b0, win_dbl[2*NUM_REQ-2:NUM_REQ]};
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte producers.
// A round-robin winner's byte is latched, a one-cycle start pulse is issued,
// the transmitter's busy flag is followed until the frame ends (or a start
// timeout fires) and the owner is then acknowledged with a one-cycle pulse.
//   clk         - clock, all state changes on the rising edge
//   i_reset_n   - synchronous active-low reset
//   bus         - requester and transmitter signals (slave modport)
//   o_dbg_state - current FSM state, for observation only
// Parameters: NUM_REQ 2..8, DATA_W byte width, START_TIMEOUT >= 2 cycles.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ       = DEFAULT_NUM_REQ,
    parameter int DATA_W        = DEFAULT_DATA_W,
    parameter int START_TIMEOUT = DEFAULT_START_TIMEOUT
) (
    input  logic              clk,
    input  logic              i_reset_n,
    uart_tx_arbiter_if.slave  bus,
    output arb_state_t        o_dbg_state
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(START_TIMEOUT) + 1;

    arb_state_t          state_q,   state_d;
    logic [NUM_REQ-1:0]  grant_q,   grant_d;
    logic [DATA_W-1:0]   data_q,    data_d;
    logic [PTR_W-1:0]    ptr_q,     ptr_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic                start_q,   start_d;
    logic [NUM_REQ-1:0]  ack_q,     ack_d;
    logic                timeout_q, timeout_d;

    logic [NUM_REQ-1:0]  pick_winner;
    logic                pick_valid;
    logic [DATA_W-1:0]   pick_data;
    logic [PTR_W-1:0]    pick_idx;
    logic [PTR_W-1:0]    ptr_next;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .i_req    (bus.i_req),
        .i_ptr    (ptr_q),
        .o_winner (pick_winner),
        .o_valid  (pick_valid)
    );

    // Winner's byte and index, decoded from the one-hot pick.
    always_comb begin
        pick_data = '0;
        pick_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_winner[k]) begin
                pick_data = bus.i_data[k*DATA_W +: DATA_W];
                pick_idx  = PTR_W'(k);
            end
        end
    end

    assign ptr_next = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        data_d    = data_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        start_d   = 1'b0;
        ack_d     = '0;
        timeout_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_winner;
                    data_d  = pick_data;
                    ptr_d   = ptr_next;
                    start_d = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // Busy is deliberately not looked at here; it is first
                // sampled in WAIT_BUSY.
                cnt_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (bus.i_uart_busy) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // Give up once the counter steps onto START_TIMEOUT-1.
                    if (cnt_q == CNT_W'(START_TIMEOUT - 2)) begin
                        ack_d     = grant_q;
                        timeout_d = 1'b1;
                        state_d   = ST_RELEASE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.i_uart_busy) begin
                    ack_d   = grant_q;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // Requests are not sampled here, which gives the owner one
                // edge to drop its request after o_ack.
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            data_q    <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            start_q   <= 1'b0;
            ack_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            data_q    <= data_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            start_q   <= start_d;
            ack_q     <= ack_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.o_start_uart = start_q;
    assign bus.o_uart_data  = data_q;
    assign bus.o_grant      = grant_q;
    assign bus.o_ack        = ack_q;
    assign bus.o_timeout    = timeout_q;
    assign o_dbg_state      = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios, a transaction-level model
// that predicts start/grant/data/ack/timeout for every cycle, and a simple
// transmitter responder that raises busy a configured time after start.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int NUM_REQ       = 4;
    localparam int DATA_W        = 8;
    localparam int START_TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       i_reset_n;
    arb_state_t dbg_state;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut_if ();

    uart_tx_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .DATA_W        (DATA_W),
        .START_TIMEOUT (START_TIMEOUT)
    ) dut (
        .clk         (clk),
        .i_reset_n   (i_reset_n),
        .bus         (dut_if.slave),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_start_cyc = -1;

    // Transmitter behaviour for the next frame: busy rises cfg_rise cycles
    // after the start pulse and stays high cfg_len cycles; cfg_rise=0 = never.
    int cfg_rise = 1;
    int cfg_len  = 1;

    // Model state.
    bit                m_on = 0;
    bit                m_active = 0;
    int                m_ptr = 0;
    int                m_free = 0;
    int                m_owner = 0;
    int                m_start = 0;
    int                m_ack = 0;
    bit                m_to = 0;
    logic [DATA_W-1:0] m_data = '0;
    int                m_k;
    int                m_w;

    // Responder state.
    bit r_active = 0;
    int r_s = 0;
    int r_rise = 0;
    int r_len = 0;

    logic [NUM_REQ-1:0] e_grant, e_ack;
    logic               e_start, e_to;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s cyc=%0d bound expired", name, cyc);
    endtask

    function automatic logic [NUM_REQ-1:0] onehot(input int k);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // Compare, then advance the model to the next edge, then drive busy.
    always @(negedge clk) begin
        cyc++;
        if (dut_if.o_start_uart) last_start_cyc = cyc;

        if (m_on) begin
            e_grant = (m_active && cyc >= m_start) ? onehot(m_owner) : '0;
            e_start = m_active && (cyc == m_start);
            e_ack   = (m_active && cyc == m_ack) ? onehot(m_owner) : '0;
            e_to    = m_active && (cyc == m_ack) && m_to;
            check("start", 32'(dut_if.o_start_uart), 32'(e_start));
            check("grant", 32'(dut_if.o_grant), 32'(e_grant));
            check("ack", 32'(dut_if.o_ack), 32'(e_ack));
            check("timeout", 32'(dut_if.o_timeout), 32'(e_to));
            if (m_active && cyc >= m_start)
                check("data", 32'(dut_if.o_uart_data), 32'(m_data));
            if (m_active && cyc == m_ack) m_active = 0;
        end

        if (!i_reset_n) begin
            m_on     = 1;
            m_active = 0;
            m_ptr    = 0;
            m_free   = cyc + 1;
        end else if (m_on && !m_active && cyc >= m_free && dut_if.i_req != '0) begin
            m_w = -1;
            for (int i = 0; i < NUM_REQ; i++) begin
                m_k = (m_ptr + i) % NUM_REQ;
                if (m_w < 0 && dut_if.i_req[m_k]) m_w = m_k;
            end
            m_owner = m_w;
            m_ptr   = (m_w + 1) % NUM_REQ;
            m_data  = dut_if.i_data[m_w*DATA_W +: DATA_W];
            m_start = cyc + 1;
            if (cfg_rise >= 1 && cfg_rise <= START_TIMEOUT - 1) begin
                m_ack = m_start + cfg_rise + cfg_len + 1;
                m_to  = 0;
            end else begin
                m_ack = m_start + START_TIMEOUT;
                m_to  = 1;
            end
            m_active = 1;
            m_free   = m_ack + 1;
        end

        if (!i_reset_n) begin
            r_active = 0;
            dut_if.i_uart_busy = 1'b0;
        end else begin
            if (dut_if.o_start_uart) begin
                r_active = 1;
                r_s      = cyc;
                r_rise   = cfg_rise;
                r_len    = cfg_len;
            end
            dut_if.i_uart_busy = r_active && r_rise >= 1 && cyc >= r_s + r_rise
                                 && cyc < r_s + r_rise + r_len;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_start();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            #1;
            if (dut_if.o_start_uart) return;
        end
        fail_now("start_wait");
    endtask

    task automatic wait_ack(output int dur, output logic [NUM_REQ-1:0] g, output logic to);
        dur = -1;
        g   = '0;
        to  = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            #1;
            if (dut_if.o_ack != '0) begin
                dur = cyc - last_start_cyc;
                g   = dut_if.o_ack;
                to  = dut_if.o_timeout;
                return;
            end
        end
        fail_now("ack_wait");
    endtask

    int                 dur;
    logic [NUM_REQ-1:0] g;
    logic               to;
    int                 acks;

    initial begin
        i_reset_n     = 1'b0;
        dut_if.i_req  = 4'b1111;
        for (int k = 0; k < NUM_REQ; k++) dut_if.i_data[k*DATA_W +: DATA_W] = 8'(8'h10 + k);
        cfg_rise = 1;
        cfg_len  = 1;

        // Reset held with every requester active: nothing may move.
        repeat (3) begin
            @(negedge clk);
            #1;
            check("rst_grant", 32'(dut_if.o_grant), 32'h0);
            check("rst_start", 32'(dut_if.o_start_uart), 32'h0);
            check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        end
        step();
        i_reset_n = 1'b1;

        // Round robin with all four requesting, minimum-length frames.
        for (int k = 0; k < NUM_REQ; k++) begin
            wait_ack(dur, g, to);
            check("rr_grant", 32'(g), 32'(1 << k));
            check("rr_dur", 32'(dur), 32'd3);
            check("rr_timeout", 32'(to), 32'h0);
            step();
            dut_if.i_req[k] = 1'b0;
        end
        step();
        dut_if.i_req = 4'b1001;
        wait_ack(dur, g, to);
        check("rr2_first", 32'(g), 32'h1);
        step();
        dut_if.i_req[0] = 1'b0;
        wait_ack(dur, g, to);
        check("rr2_second", 32'(g), 32'h8);
        step();
        dut_if.i_req[3] = 1'b0;

        // Single request, busy rises 2 cycles after start for 10 cycles.
        cfg_rise = 2;
        cfg_len  = 10;
        step();
        dut_if.i_data[2*DATA_W +: DATA_W] = 8'h41;
        dut_if.i_req[2] = 1'b1;
        wait_ack(dur, g, to);
        check("single_grant", 32'(g), 32'h4);
        check("single_dur", 32'(dur), 32'd13);
        check("single_data", 32'(dut_if.o_uart_data), 32'h41);
        step();
        dut_if.i_req[2] = 1'b0;

        // Data changes after the grant must not reach the transmitter.
        cfg_rise = 3;
        cfg_len  = 4;
        step();
        dut_if.i_data[1*DATA_W +: DATA_W] = 8'h41;
        dut_if.i_req[1] = 1'b1;
        wait_start();
        step();
        dut_if.i_data[1*DATA_W +: DATA_W] = 8'h42;
        wait_ack(dur, g, to);
        check("stable_grant", 32'(g), 32'h2);
        check("stable_dur", 32'(dur), 32'd8);
        check("stable_data", 32'(dut_if.o_uart_data), 32'h41);
        step();
        dut_if.i_req[1] = 1'b0;

        // Transmitter never goes busy.
        cfg_rise = 0;
        cfg_len  = 0;
        step();
        dut_if.i_data[3*DATA_W +: DATA_W] = 8'h5a;
        dut_if.i_req[3] = 1'b1;
        wait_ack(dur, g, to);
        check("to_grant", 32'(g), 32'h8);
        check("to_flag", 32'(to), 32'h1);
        check("to_dur", 32'(dur), 32'd16);
        step();
        dut_if.i_req[3] = 1'b0;

        // Normal service after a timeout.
        cfg_rise = 1;
        cfg_len  = 2;
        step();
        dut_if.i_data[0*DATA_W +: DATA_W] = 8'h33;
        dut_if.i_req[0] = 1'b1;
        wait_ack(dur, g, to);
        check("after_to_grant", 32'(g), 32'h1);
        check("after_to_flag", 32'(to), 32'h0);
        check("after_to_dur", 32'(dur), 32'd4);
        check("after_to_data", 32'(dut_if.o_uart_data), 32'h33);
        step();
        dut_if.i_req[0] = 1'b0;

        // Reset in WAIT_DONE: owner 0 moves the pointer to 1, reset must
        // bring it back so requester 0 beats requester 3.
        cfg_rise = 1;
        cfg_len  = 20;
        step();
        dut_if.i_req[0] = 1'b1;
        wait_start();
        repeat (3) @(posedge clk);
        step();
        i_reset_n    = 1'b0;
        dut_if.i_req = 4'b1001;
        cfg_rise = 1;
        cfg_len  = 1;
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (dut_if.o_ack != '0 || dut_if.o_timeout) acks++;
        end
        check("rst_mid_noack", 32'(acks), 32'd0);
        step();
        i_reset_n = 1'b1;
        wait_ack(dur, g, to);
        check("rst_mid_first", 32'(g), 32'h1);
        step();
        dut_if.i_req[0] = 1'b0;
        wait_ack(dur, g, to);
        check("rst_mid_second", 32'(g), 32'h8);
        step();
        dut_if.i_req[3] = 1'b0;

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d simulation did not finish", cyc);
        $fatal(1);
    end

endmodule
